// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell, LSB-first,
// registered carry/borrow, serial and parallel result outputs.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             sbit,
    output logic             sbit_valid
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] sa, sb;
    logic             opr;
    logic             c;
    logic [CW-1:0]    cnt;

    logic ai, bi, s, cn, last, accept;

    always_comb begin
        ai      = sa[0];
        bi      = sb[0];
        s       = ai ^ bi ^ c;
        cn      = opr ? ((~ai & bi) | (~(ai ^ bi) & c))
                      : ((ai & bi) | (c & (ai ^ bi)));
        last    = (cnt == CW'(WIDTH - 1));
        accept  = (state == IDLE) && start;
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = RUN;
            RUN:  if (last)  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Result fills from the MSB end so bit i lands at result[i] after WIDTH shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            opr        <= 1'b0;
            c          <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            cout       <= 1'b0;
            sbit       <= 1'b0;
            sbit_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            sbit_valid <= 1'b0;
            done       <= 1'b0;
            if (accept) begin
                sa  <= a;
                sb  <= b;
                opr <= op;
                c   <= 1'b0;
                cnt <= '0;
            end else if (state == RUN) begin
                sa         <= sa >> 1;
                sb         <= sb >> 1;
                result     <= {s, result[WIDTH-1:1]};
                sbit       <= s;
                sbit_valid <= 1'b1;
                c          <= cn;
                cnt        <= cnt + 1'b1;
                if (last) begin
                    done <= 1'b1;
                    cout <= cn;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases, random ops,
// mid-run start, async reset abort and back-to-back chaining.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] a, b;
    logic       busy, done, cout, sbit, sbit_valid;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .cout(cout),
        .sbit(sbit), .sbit_valid(sbit_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 9 bits.
    function automatic logic [8:0] model(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic o);
        int r;
        if (!o) r = int'(x) + int'(y);
        else    r = int'(x) - int'(y);
        return {(o ? (x < y) : (r > 255)), 8'(r & 255)};
    endfunction

    // Runs one op. If chained, start/a/b/op already set before the accept edge.
    // poke >= 0: drive a spurious start with other operands after bit poke.
    // nxt: at the done cycle drive start with the next operands.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          input logic xo, input bit chained, input int poke,
                          input bit nxt, input logic [7:0] na,
                          input logic [7:0] nb, input logic no);
        logic [8:0] e;
        e = model(xa, xb, xo);
        if (!chained) begin
            @(negedge clk);
            start = 1'b1; a = xa; b = xb; op = xo;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("valid_before_bit0", 32'(sbit_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("sbit_valid", 32'(sbit_valid), 32'd1);
            chk("sbit", 32'(sbit), 32'(e[i]));
            chk("done_timing", 32'(done), 32'(i == 7));
            chk("busy_timing", 32'(busy), 32'(i != 7));
            if (i == 7) begin
                chk("result", 32'(result), 32'(e[7:0]));
                chk("cout", 32'(cout), 32'(e[8]));
                if (nxt) begin
                    start = 1'b1; a = na; b = nb; op = no;
                end
            end
            if (i == poke) begin
                start = 1'b1; a = ~xa; b = xb ^ 8'h5a; op = ~xo;
            end
        end
        if (!nxt) begin
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("valid_drop", 32'(sbit_valid), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_sbit_valid", 32'(sbit_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the plan, with literal expectations too.
        run_op(8'hFF, 8'h01, 1'b0, 0, -1, 0, 8'h0, 8'h0, 1'b0);
        chk("ff+01_result", 32'(result), 32'h00);
        chk("ff+01_cout", 32'(cout), 32'd1);
        run_op(8'h3C, 8'h27, 1'b0, 0, -1, 0, 8'h0, 8'h0, 1'b0);
        chk("3c+27_result", 32'(result), 32'h63);
        run_op(8'h37, 8'h12, 1'b1, 0, -1, 0, 8'h0, 8'h0, 1'b0);
        chk("37-12_result", 32'(result), 32'h25);
        run_op(8'h05, 8'h07, 1'b1, 0, -1, 0, 8'h0, 8'h0, 1'b0);
        chk("05-07_result", 32'(result), 32'hFE);
        chk("05-07_borrow", 32'(cout), 32'd1);

        // Boundary operands.
        run_op(8'h00, 8'h00, 1'b1, 0, -1, 0, 8'h0, 8'h0, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1, 0, -1, 0, 8'h0, 8'h0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 0, -1, 0, 8'h0, 8'h0, 1'b0);

        // Spurious start during cycle 3 of a run is ignored.
        run_op(8'h9A, 8'h4B, 1'b0, 0, 2, 0, 8'h0, 8'h0, 1'b0);

        // Async reset during bit 4.
        @(negedge clk);
        start = 1'b1; a = 8'hC3; b = 8'h3C; op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_sbit", 32'(sbit), 32'd0);
        chk("arst_valid", 32'(sbit_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", 32'(done), 32'd0);
        end
        run_op(8'h81, 8'h7F, 1'b1, 0, -1, 0, 8'h0, 8'h0, 1'b0);

        // Back-to-back: start held across the done cycle.
        run_op(8'h12, 8'h34, 1'b0, 0, -1, 1, 8'hA0, 8'hB1, 1'b1);
        run_op(8'hA0, 8'hB1, 1'b1, 1, -1, 0, 8'h0, 8'h0, 1'b0);

        // Random ops.
        for (int k = 0; k < 24; k++) begin
            logic [7:0] ra, rb;
            logic ro;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ro = 1'($urandom_range(0, 1));
            run_op(ra, rb, ro, 0, -1, 0, 8'h0, 8'h0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
